// File: rtl/ll_pkg.sv
// Shared types and helpers for the lander state bank: BCD word check and history op encoding.
package ll_pkg;
  localparam int BCD_DIGIT_W = 4;
  localparam int DEF_NDIG    = 4;
  localparam int MAX_NDIG    = 16;
  localparam int MAX_W       = BCD_DIGIT_W * MAX_NDIG;

  typedef enum logic [1:0] {HOP_NONE, HOP_PUSH, HOP_POP} hist_op_e;

  // Callers zero-extend their field to MAX_W; only the low ndig digits are examined.
  function automatic logic is_bcd_word(input logic [MAX_W-1:0] v, input int ndig);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < MAX_NDIG; i++) begin
      if (i < ndig && v[i*BCD_DIGIT_W +: BCD_DIGIT_W] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction
endpackage

// File: rtl/ll_hist_stack.sv
// Circular LIFO of snapshots; pushing while full overwrites the oldest entry and pulses ovf.
module ll_hist_stack
  import ll_pkg::*;
#(
  parameter int EW    = 64,
  parameter int DEPTH = 8,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  hist_op_e      op,
  input  logic [EW-1:0] din,
  output logic [EW-1:0] dout,
  output logic [CW-1:0] count,
  output logic          ovf
);
  localparam int PW = $clog2(DEPTH);
  localparam int IW = CW + 2;

  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] base;
  logic [PW-1:0] top_idx;
  logic [PW-1:0] new_idx;
  logic          full;

  function automatic logic [PW-1:0] wrap(input logic [IW-1:0] v);
    return PW'(v % IW'(DEPTH));
  endfunction

  // Free slot sits count entries past base; newest entry sits one below it (mod DEPTH).
  assign top_idx = wrap(IW'(base) + IW'(count));
  assign new_idx = wrap(IW'(base) + IW'(count) + IW'(DEPTH - 1));
  assign dout    = mem[new_idx];
  assign full    = (count == CW'(DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      base  <= '0;
      ovf   <= 1'b0;
    end else begin
      ovf <= 1'b0;
      case (op)
        HOP_PUSH: begin
          if (full) begin
            base <= wrap(IW'(base) + IW'(1));
            ovf  <= 1'b1;
          end else begin
            count <= count + 1'b1;
          end
        end
        HOP_POP: if (count != '0) count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (op == HOP_PUSH) mem[top_idx] <= din;
  end
endmodule

// File: rtl/ll_state_bank.sv
// Live BCD lander state with snapshot history, rewind and non-BCD write rejection.
// Optional LL_LOCK_ON_LAND_EN adds a landed input that freezes writes/snaps until a rewind.
module ll_state_bank
  import ll_pkg::*;
#(
  parameter int NDIG       = DEF_NDIG,
  parameter int HIST_DEPTH = 8,
  parameter logic [4*NDIG-1:0] ALT_INIT    = 'h4500,
  parameter logic [4*NDIG-1:0] VEL_INIT    = 'h0,
  parameter logic [4*NDIG-1:0] FUEL_INIT   = 'h800,
  parameter logic [4*NDIG-1:0] THRUST_INIT = 'h5
) (
  input  logic                              clk,
  input  logic                              rst,
`ifdef LL_LOCK_ON_LAND_EN
  input  logic                              landed,
`endif
  input  logic                              wen,
  input  logic [4*NDIG-1:0]                 alt_n,
  input  logic [4*NDIG-1:0]                 vel_n,
  input  logic [4*NDIG-1:0]                 fuel_n,
  input  logic [4*NDIG-1:0]                 thrust_n,
  input  logic                              snap,
  input  logic                              rewind,
  output logic [4*NDIG-1:0]                 alt,
  output logic [4*NDIG-1:0]                 vel,
  output logic [4*NDIG-1:0]                 fuel,
  output logic [4*NDIG-1:0]                 thrust,
  output logic [$clog2(HIST_DEPTH+1)-1:0]   hist_count,
  output logic                              hist_empty,
  output logic                              hist_full,
  output logic                              bcd_err,
  output logic                              hist_err,
  output logic                              hist_ovf
);
  localparam int W  = 4 * NDIG;
  localparam int CW = $clog2(HIST_DEPTH + 1);

  logic           locked;
  logic           pop_ok;
  logic           wen_eff;
  logic           bcd_ok;
  logic           commit;
  logic           snap_eff;
  hist_op_e       op;
  logic [4*W-1:0] hist_dout;

  assign pop_ok   = rewind && (hist_count != '0);
  assign wen_eff  = wen && !rewind && !locked;
  assign bcd_ok   = is_bcd_word(MAX_W'(alt_n), NDIG) && is_bcd_word(MAX_W'(vel_n), NDIG) &&
                    is_bcd_word(MAX_W'(fuel_n), NDIG) && is_bcd_word(MAX_W'(thrust_n), NDIG);
  assign commit   = wen_eff && bcd_ok;
  assign snap_eff = snap && !rewind && !locked;

  always_comb begin
    op = HOP_NONE;
    if (pop_ok)        op = HOP_POP;
    else if (snap_eff) op = HOP_PUSH;
  end

  ll_hist_stack #(.EW(4*W), .DEPTH(HIST_DEPTH)) u_hist (
    .clk   (clk),
    .rst   (rst),
    .op    (op),
    .din   ({alt, vel, fuel, thrust}),
    .dout  (hist_dout),
    .count (hist_count),
    .ovf   (hist_ovf)
  );

  assign hist_empty = (hist_count == '0);
  assign hist_full  = (hist_count == CW'(HIST_DEPTH));

  // Live registers: rewind outranks a write; a write lands all four fields or none.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alt      <= ALT_INIT;
      vel      <= VEL_INIT;
      fuel     <= FUEL_INIT;
      thrust   <= THRUST_INIT;
      bcd_err  <= 1'b0;
      hist_err <= 1'b0;
    end else begin
      bcd_err  <= wen_eff && !bcd_ok;
      hist_err <= rewind && (hist_empty || snap);
      if (pop_ok) begin
        {alt, vel, fuel, thrust} <= hist_dout;
      end else if (commit) begin
        alt    <= alt_n;
        vel    <= vel_n;
        fuel   <= fuel_n;
        thrust <= thrust_n;
      end
    end
  end

`ifdef LL_LOCK_ON_LAND_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         locked <= 1'b0;
    else if (pop_ok) locked <= 1'b0;
    else if (landed) locked <= 1'b1;
  end
`else
  assign locked = 1'b0;
`endif
endmodule
